gray_ptr_sync: RTL and testbench

//   Parametrised clock-domain-crossing synchroniser for async-FIFO gray pointers.

---
 rtl/fifo_pkg.sv | 34 +++
 rtl/sync_chain.sv | 30 +++
 rtl/gray_ptr_sync.sv | 80 ++++++++
 tb/tb_gray_ptr_sync.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the async-FIFO pointer logic: gray/binary conversion,
// bit counting and the legal synchroniser depth range.
package fifo_pkg;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 4;

    // Helpers work on a fixed wide vector; callers zero-extend and truncate.
    localparam int PTR_MAX_W = 32;
    localparam int CNT_W     = $clog2(PTR_MAX_W + 1);

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [PTR_MAX_W-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < PTR_MAX_W; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Bare multi-flop synchroniser with synchronous reset; exposes the last stage
// and the one before it so the consumer can see the next value one edge early.
module sync_chain #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_last,
    output logic [WIDTH-1:0] o_prev
);

    logic [STAGES-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int k = 1; k < STAGES; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign o_last = r_stage[STAGES-1];
    assign o_prev = r_stage[STAGES-2];

endmodule

// File: rtl/gray_ptr_sync.sv
// Gray pointer synchroniser for one side of an async FIFO: delivers the synced
// gray value, its binary form, an update pulse, the pointer delta and a sticky
// multi-bit-change error, all aligned to the same edge.
module gray_ptr_sync
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE = 4,
    parameter int STAGES   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDRSIZE:0] ptr_in,
    input  logic              err_clr,
    output logic [ADDRSIZE:0] ptr_out,
    output logic [ADDRSIZE:0] ptr_bin_out,
    output logic              ptr_changed,
    output logic [ADDRSIZE:0] ptr_delta,
    output logic              gray_err
);

    localparam int W = ADDRSIZE + 1;

    generate
        if (STAGES < MIN_SYNC_STAGES || STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
            $error("gray_ptr_sync: STAGES=%0d outside legal range %0d..%0d",
                   STAGES, MIN_SYNC_STAGES, MAX_SYNC_STAGES);
        end
    endgenerate

    logic [W-1:0] w_last;
    logic [W-1:0] w_nxt;
    logic [W-1:0] w_nxt_bin;
    logic         w_multi_bit;

    logic [W-1:0] r_bin;
    logic         r_changed;
    logic [W-1:0] r_delta;
    logic         r_err;

    sync_chain #(
        .WIDTH  (W),
        .STAGES (STAGES)
    ) u_chain (
        .clk    (clk),
        .rst    (rst),
        .i_d    (ptr_in),
        .o_last (w_last),
        .o_prev (w_nxt)
    );

    // Everything below is computed from the value the last stage is about to
    // take, so the binary, pulse and delta land on the same edge as ptr_out.
    assign w_nxt_bin   = W'(gray2bin(PTR_MAX_W'(w_nxt)));
    assign w_multi_bit = (popcount(PTR_MAX_W'(w_nxt ^ w_last)) > CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin     <= '0;
            r_changed <= 1'b0;
            r_delta   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_bin     <= w_nxt_bin;
            r_changed <= (w_nxt != w_last);
            r_delta   <= w_nxt_bin - r_bin;
            if (w_multi_bit) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign ptr_out     = w_last;
    assign ptr_bin_out = r_bin;
    assign ptr_changed = r_changed;
    assign ptr_delta   = r_delta;
    assign gray_err    = r_err;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Bench for gray_ptr_sync: directed scenarios plus random pointer traffic,
// every cycle compared against a delay-line reference model.
module tb_gray_ptr_sync;

    localparam int ADDRSIZE = 4;
    localparam int STAGES   = 3;
    localparam int W        = ADDRSIZE + 1;
    localparam int NPTR     = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         err_clr;
    logic [W-1:0] ptr_in;
    logic [W-1:0] ptr_out;
    logic [W-1:0] ptr_bin_out;
    logic         ptr_changed;
    logic [W-1:0] ptr_delta;
    logic         gray_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: values waiting in the chain (front = newest) plus the
    // currently delivered outputs.
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_out;
    logic [W-1:0] m_bin;
    logic [W-1:0] m_delta;
    logic         m_changed;
    logic         m_err;

    gray_ptr_sync #(
        .ADDRSIZE (ADDRSIZE),
        .STAGES   (STAGES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ptr_in      (ptr_in),
        .err_clr     (err_clr),
        .ptr_out     (ptr_out),
        .ptr_bin_out (ptr_bin_out),
        .ptr_changed (ptr_changed),
        .ptr_delta   (ptr_delta),
        .gray_err    (gray_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_gray(input int b);
        int g;
        g = (b ^ (b >> 1)) % NPTR;
        return W'(g);
    endfunction

    // Inverse by search over the code table.
    function automatic logic [W-1:0] from_gray(input logic [W-1:0] g);
        for (int b = 0; b < NPTR; b++) begin
            if (to_gray(b) == g) return W'(b);
        end
        return '0;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [W-1:0] nxt;
        logic [W-1:0] nbin;
        if (rst) begin
            m_q = {};
            for (int i = 0; i < STAGES - 1; i++) m_q.push_front('0);
            m_out     = '0;
            m_bin     = '0;
            m_delta   = '0;
            m_changed = 1'b0;
            m_err     = 1'b0;
        end else begin
            nxt = m_q[$];
            void'(m_q.pop_back());
            m_q.push_front(ptr_in);
            nbin      = from_gray(nxt);
            m_changed = (nxt != m_out);
            m_delta   = W'((int'(nbin) - int'(m_bin) + NPTR) % NPTR);
            if ($countones(nxt ^ m_out) > 1) m_err = 1'b1;
            else if (err_clr)                m_err = 1'b0;
            m_out = nxt;
            m_bin = nbin;
        end
    endtask

    task automatic step(input logic [W-1:0] p, input logic c, input logic r);
        ptr_in  = p;
        err_clr = c;
        rst     = r;
        @(posedge clk);
        model_edge();
        #1;
        check("ptr_out",     32'(ptr_out),     32'(m_out));
        check("ptr_bin_out", 32'(ptr_bin_out), 32'(m_bin));
        check("ptr_changed", 32'(ptr_changed), 32'(m_changed));
        check("ptr_delta",   32'(ptr_delta),   32'(m_delta));
        check("gray_err",    32'(gray_err),    32'(m_err));
    endtask

    initial begin
        int cnt;
        ptr_in  = '0;
        err_clr = 1'b0;
        rst     = 1'b1;

        // Reset held with a busy input, then release
        repeat (3) step(5'h1F, 1'b0, 1'b1);
        check("rst_ptr_out", 32'(ptr_out), 32'h0);
        check("rst_changed", 32'(ptr_changed), 32'h0);
        check("rst_err",     32'(gray_err), 32'h0);
        for (int k = 1; k <= STAGES; k++) begin
            step(5'h1F, 1'b0, 1'b0);
            if (k < STAGES) check("rel_early", 32'(ptr_out), 32'h0);
        end
        check("rel_ptr_out", 32'(ptr_out), 32'h1F);
        step(5'h1F, 1'b1, 1'b0);

        // Latency from a quiet zero pointer
        step(5'h00, 1'b0, 1'b1);
        repeat (STAGES + 1) step(5'h00, 1'b0, 1'b0);
        check("quiet_changed", 32'(ptr_changed), 32'h0);
        for (int k = 1; k <= STAGES + 1; k++) begin
            step(5'h01, 1'b0, 1'b0);
            if (k == STAGES) begin
                check("lat_out",     32'(ptr_out), 32'h01);
                check("lat_bin",     32'(ptr_bin_out), 32'h1);
                check("lat_changed", 32'(ptr_changed), 32'h1);
                check("lat_delta",   32'(ptr_delta), 32'h1);
            end else begin
                check("lat_nopulse", 32'(ptr_changed), 32'h0);
            end
        end

        // Count sweep through the wrap
        for (int v = 2; v <= NPTR; v++) begin
            repeat (2) step(to_gray(v % NPTR), 1'b0, 1'b0);
        end
        repeat (STAGES) step(5'h00, 1'b0, 1'b0);
        check("sweep_err", 32'(gray_err), 32'h0);
        check("sweep_end", 32'(ptr_out), 32'h00);

        // Multi-step jump gray(3) -> gray(6)
        repeat (STAGES + 1) step(5'h02, 1'b0, 1'b0);
        repeat (STAGES) step(5'h05, 1'b0, 1'b0);
        check("ms_delta", 32'(ptr_delta), 32'h3);
        check("ms_err",   32'(gray_err), 32'h1);
        repeat (4) step(5'h05, 1'b0, 1'b0);
        check("ms_sticky", 32'(gray_err), 32'h1);
        step(5'h05, 1'b1, 1'b0);
        check("ms_clear", 32'(gray_err), 32'h0);

        // Clear in the same cycle as a new violation
        repeat (STAGES - 1) step(5'h00, 1'b0, 1'b0);
        step(5'h00, 1'b1, 1'b0);
        check("prio_err", 32'(gray_err), 32'h1);
        step(5'h00, 1'b1, 1'b0);
        check("prio_clear", 32'(gray_err), 32'h0);

        // Reset mid-stream with 5'h0C in the chain
        repeat (STAGES + 1) step(5'h0C, 1'b0, 1'b0);
        check("mid_hold", 32'(ptr_out), 32'h0C);
        step(5'h0C, 1'b0, 1'b1);
        check("mid_rst_out",     32'(ptr_out), 32'h0);
        check("mid_rst_changed", 32'(ptr_changed), 32'h0);
        repeat (STAGES + 1) step(5'h0C, 1'b0, 1'b0);
        step(5'h0C, 1'b1, 1'b0);

        // Random traffic: mostly legal increments, some jumps, clears and resets
        cnt = int'(from_gray(ptr_in));
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 8)       cnt = int'($urandom_range(0, NPTR - 1));
            else if (r < 60) cnt = (cnt + 1) % NPTR;
            step(to_gray(cnt), ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
